// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command-side controller:
// opcode encodings, controller state encoding and the default data width.
package alu_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Controller sequence: take a command, let the ALU settle one cycle,
    // then present the captured result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } ctrl_state_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Purely combinational W-bit ALU. Carry is the carry-out for add, the borrow
// for sub, the shifted-out bit for shifts and 0 for logic ops; zero flags an
// all-zero result.
module alu
    import alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] y,
    output logic         carry,
    output logic         zero
);

    logic [W:0] ext;

    // Compute the result with one extra bit that carries the flag.
    always_comb begin
        // NOTE: default every combinational output first so no path through
        // the case leaves it unassigned, which would infer a latch.
        ext = '0;
        case (op)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            OP_AND:  ext = {1'b0, a & b};
            OP_OR:   ext = {1'b0, a | b};
            OP_XOR:  ext = {1'b0, a ^ b};
            OP_NOT:  ext = {1'b0, ~a};
            OP_SHL:  ext = {a, 1'b0};
            OP_SHR:  ext = {a[0], 1'b0, a[W-1:1]};
            default: ext = '0;
        endcase
    end

    assign y     = ext[W-1:0];
    assign carry = ext[W];
    assign zero  = (ext[W-1:0] == '0);

endmodule : alu

// File: rtl/alu_seq_ctrl.sv
// Command-side controller for one ALU instance. Accepts a command, drives the
// registered ALU operands, captures the result and flags one cycle later and
// offers them on a valid/ready result stream. Keeps an accumulator for
// chained operations and a saturating count of completed operations.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_wr_acc,

    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_carry,
    input  logic             alu_zero,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_y,
    output logic             res_carry,
    output logic             res_zero,

    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic        accept;
    logic        res_fire;
    logic        wr_acc_q;

    assign accept   = cmd_valid && (state == ST_IDLE);
    assign res_fire = res_ready && (state == ST_RESP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always written with <= so every register
        // samples the pre-edge values of the others, independent of order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> RESP always,
    // RESP -> IDLE on the result handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  if (res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_RESP:  res_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
                res_valid = 1'b0;
            end
        endcase
    end

    // ALU operand registers: loaded only on accept so the ALU inputs never
    // toggle between commands. Operand A may come from the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_ADD;
            wr_acc_q <= 1'b0;
        end else if (accept) begin
            alu_a    <= cmd_use_acc ? acc : cmd_a;
            alu_b    <= cmd_b;
            alu_op   <= cmd_op;
            wr_acc_q <= cmd_wr_acc;
        end
    end

    // Result capture in ISSUE; values then hold through any RESP stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y     <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
        end else if (state == ST_ISSUE) begin
            res_y     <= alu_y;
            res_carry <= alu_carry;
            res_zero  <= alu_zero;
        end
    end

    // Accumulator write-back in ISSUE, so a back-to-back chained command
    // accepted in the following IDLE already sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if ((state == ST_ISSUE) && wr_acc_q) begin
            acc <= alu_y;
        end
    end

    // Completed-operation counter, bumped on the result handshake and
    // pinned at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (res_fire && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule : alu_seq_ctrl

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl wired to an alu instance. A table of
// single commands with hand-computed results covers the opcode sweep, the
// accumulator chain and overflow; hand-written sequences cover backpressure,
// reset in ISSUE and counter saturation (on a narrow-counter instance).
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;

    logic         cmd_valid, cmd_ready, cmd_use_acc, cmd_wr_acc;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a, cmd_b;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic [2:0]   alu_op;
    logic         alu_carry, alu_zero;
    logic         res_valid, res_ready, res_carry, res_zero;
    logic [W-1:0] res_y, acc;
    logic [15:0]  op_count;

    // Second pair with a 4-bit counter to reach saturation quickly.
    logic         s_cmd_valid, s_cmd_ready;
    logic [W-1:0] s_alu_a, s_alu_b, s_alu_y, s_res_y, s_acc;
    logic [2:0]   s_alu_op;
    logic         s_alu_carry, s_alu_zero, s_res_valid, s_res_carry, s_res_zero;
    logic [3:0]   s_op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.W(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_carry(res_carry), .res_zero(res_zero),
        .acc(acc), .op_count(op_count)
    );

    alu #(.W(W)) u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op),
        .y(alu_y), .carry(alu_carry), .zero(alu_zero)
    );

    alu_seq_ctrl #(.W(W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(OP_ADD),
        .cmd_a(8'h01), .cmd_b(8'h01), .cmd_use_acc(1'b0), .cmd_wr_acc(1'b0),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
        .alu_y(s_alu_y), .alu_carry(s_alu_carry), .alu_zero(s_alu_zero),
        .res_valid(s_res_valid), .res_ready(1'b1), .res_y(s_res_y),
        .res_carry(s_res_carry), .res_zero(s_res_zero),
        .acc(s_acc), .op_count(s_op_count)
    );

    alu #(.W(W)) u_alu_sat (
        .a(s_alu_a), .b(s_alu_b), .op(s_alu_op),
        .y(s_alu_y), .carry(s_alu_carry), .zero(s_alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         use_acc;
        logic         wr_acc;
        logic [W-1:0] exp_alu_a;
        logic [W-1:0] exp_y;
        logic         exp_carry;
        logic         exp_zero;
        logic [W-1:0] exp_acc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for cmd_ready, presents one command for a single edge,
    // and returns #1 after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic use_acc, input logic wr_acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_wr_acc  = wr_acc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = OP_ADD;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        cmd_wr_acc  = 1'b0;
        res_ready   = 1'b1;
        s_cmd_valid = 1'b0;

        //             op      a      b      ua  wa  alu_a  y      c  z  acc
        vecs[0]  = '{OP_ADD, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h0F, 0, 0, 8'h00};
        vecs[1]  = '{OP_SUB, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h05, 0, 0, 8'h00};
        vecs[2]  = '{OP_AND, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h00, 0, 1, 8'h00};
        vecs[3]  = '{OP_OR,  8'h0A, 8'h05, 0, 0, 8'h0A, 8'h0F, 0, 0, 8'h00};
        vecs[4]  = '{OP_XOR, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h0F, 0, 0, 8'h00};
        vecs[5]  = '{OP_NOT, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'hF5, 0, 0, 8'h00};
        vecs[6]  = '{OP_SHL, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h14, 0, 0, 8'h00};
        vecs[7]  = '{OP_SHR, 8'h0A, 8'h05, 0, 0, 8'h0A, 8'h05, 0, 0, 8'h00};
        vecs[8]  = '{OP_ADD, 8'h01, 8'h02, 0, 1, 8'h01, 8'h03, 0, 0, 8'h03};
        vecs[9]  = '{OP_ADD, 8'hAA, 8'h04, 1, 1, 8'h03, 8'h07, 0, 0, 8'h07};
        vecs[10] = '{OP_ADD, 8'hFF, 8'h01, 0, 0, 8'hFF, 8'h00, 1, 1, 8'h07};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_res_y",     32'(res_y),     32'd0);
        check("rst_res_flags", 32'({res_carry, res_zero}), 32'd0);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        rst_n = 1'b1;

        // Table: one command each with res_ready high; checks the 2-cycle latency.
        for (int i = 0; i < 11; i++) begin
            send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].wr_acc);
            check("t0_cmd_ready", 32'(cmd_ready), 32'd0);
            check("t0_res_valid", 32'(res_valid), 32'd0);
            check("t0_alu_a",     32'(alu_a),     32'(vecs[i].exp_alu_a));
            check("t0_alu_b",     32'(alu_b),     32'(vecs[i].b));
            check("t0_alu_op",    32'(alu_op),    32'(vecs[i].op));
            @(posedge clk); #1;
            check("t1_res_valid", 32'(res_valid), 32'd1);
            check("t1_res_y",     32'(res_y),     32'(vecs[i].exp_y));
            check("t1_res_carry", 32'(res_carry), 32'(vecs[i].exp_carry));
            check("t1_res_zero",  32'(res_zero),  32'(vecs[i].exp_zero));
            check("t1_acc",       32'(acc),       32'(vecs[i].exp_acc));
            @(posedge clk); #1;
            check("t2_res_valid", 32'(res_valid), 32'd0);
            check("t2_cmd_ready", 32'(cmd_ready), 32'd1);
            check("t2_op_count",  32'(op_count),  32'(i + 1));
        end

        // Backpressure: result held 10 cycles while a competing command is offered.
        res_ready = 1'b0;
        send_cmd(OP_XOR, 8'h3C, 8'hFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = OP_ADD;
            cmd_a     = 8'h55;
            cmd_b     = 8'h66;
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_y",     32'(res_y),     32'hC3);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_a",     32'(alu_a),     32'h3C);
            check("bp_op_count",  32'(op_count),  32'd11);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_res_valid", 32'(res_valid), 32'd0);
        check("bp_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp_rel_op_count",  32'(op_count),  32'd12);
        @(posedge clk); #1;
        check("bp_single_hs",     32'(op_count),  32'd12);
        check("bp_no_new_cmd",    32'(res_valid), 32'd0);

        // Reset asserted while the command sits in ISSUE.
        send_cmd(OP_ADD, 8'h10, 8'h20, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check("mid_rst_alu_b",     32'(alu_b),     32'd0);
        check("mid_rst_res_y",     32'(res_y),     32'd0);
        check("mid_rst_acc",       32'(acc),       32'd0);
        check("mid_rst_op_count",  32'(op_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_res_valid", 32'(res_valid), 32'd0);
            check("post_rst_op_count",  32'(op_count),  32'd0);
            check("post_rst_acc",       32'(acc),       32'd0);
        end

        // Saturation on the 4-bit counter instance: 17 ops, pinned at 15.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            s_cmd_valid = 1'b1;
            @(posedge clk); #1;
            s_cmd_valid = 1'b0;
            @(posedge clk); #1;
            check("sat_res_y", 32'(s_res_y), 32'h02);
            @(posedge clk); #1;
            check("sat_op_count", 32'(s_op_count), 32'((i + 1 > 15) ? 15 : i + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq_ctrl

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command-side controller for the 8-bit ALU: accepts operation commands over a valid/ready stream, drives the ALU's `a`/`b`/`op` inputs from registers, and captures `y`/`carry`/`zero` into a result stream. It keeps an accumulator so operations can be chained, and a saturating count of completed operations. It sits between a command source (sequencer or host bus adapter) and one `alu` instance, connected in the parent.

## Interface
- `W`, 8, data width; must match the ALU.
- `CNT_W`, 16, width of the completed-operation counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 shl, 111 shr.
- `cmd_a`, `cmd_b`  in  W  operands.
- `cmd_use_acc`  in  1  operand A is taken from the accumulator instead of `cmd_a`.
- `cmd_wr_acc`  in  1  the result is written to the accumulator.
- `alu_a`, `alu_b`  out  W  registered ALU operands.
- `alu_op`  out  3  registered ALU opcode.
- `alu_y`  in  W  ALU result; combinational from `alu_a`/`alu_b`/`alu_op`.
- `alu_carry`, `alu_zero`  in  1  ALU flags.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts the result.
- `res_y`  out  W  captured result.
- `res_carry`, `res_zero`  out  1  captured flags.
- `acc`  out  W  accumulator value.
- `op_count`  out  CNT_W  completed operations, saturating.

## Operation
- States: IDLE, ISSUE, RESP; reset state is IDLE.
- `cmd_ready` = (state == IDLE).
- IDLE, `cmd_valid` high:
  - Accept the command.
  - `alu_a` <= `cmd_use_acc` ? `acc` : `cmd_a`; `alu_b` <= `cmd_b`; `alu_op` <= `cmd_op`.
  - Latch `cmd_wr_acc` internally; go to ISSUE.
- ISSUE (one cycle, ALU settles):
  - `res_y`/`res_carry`/`res_zero` <= `alu_y`/`alu_carry`/`alu_zero`.
  - If the latched `wr_acc` is set, `acc` <= `alu_y`.
  - Go to RESP.
- RESP:
  - `res_valid` = 1.
  - On `res_ready`: go to IDLE and increment `op_count`; at all-ones it holds.
  - While `res_ready` is low, hold `res_*` stable.
- `alu_a`/`alu_b`/`alu_op` hold their last values between commands; no spurious ALU input toggles.
- Flag semantics belong to the ALU; the controller passes them through unmodified.
- `cmd_b` is always used directly; only operand A can come from the accumulator.

## Timing
- Reset (async assert): state IDLE, `cmd_ready`=1, `res_valid`=0. `alu_a`, `alu_b`, `alu_op`, `res_y`, `res_carry`, `res_zero`, `acc` and `op_count` are all 0.
- Reset mid-operation: any in-flight command and result are dropped; no count increment.
- Latency: command accepted at edge T0 → `res_valid` high after edge T1 (2 cycles if `res_ready` is held high).
- Throughput: one command per 3 cycles with `res_ready` held high.
- `cmd_use_acc` samples the accumulator at the acceptance edge. A back-to-back chained command sees the previous result, because acc is written in ISSUE, before the next IDLE.
- Backpressure: unbounded RESP stall is legal; `cmd_ready` stays 0 throughout.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD`…`OP_SHR` (3 bits);
  - controller state encoding;
  - `W` default.
- No sub-module. The `alu` instance lives in the parent and is wired `alu_a`→`a`, `alu_b`→`b`, `alu_op`→`op`, `y`→`alu_y`, `carry`→`alu_carry`, `zero`→`alu_zero`.
- The bench instantiates controller plus `alu`.

## Test plan
- Add: cmd add a=0x0A b=0x05, `res_ready`=1 → `res_valid` 2 cycles after accept, `res_y`=0x0F, zero=0; `op_count`=1.
- Opcode sweep: sub, and, or, xor, not, shl, shr with a=0x0A b=0x05 → `res_y` 0x05, 0x00 (zero=1), 0x0F, 0x0F, 0xF5, 0x14, 0x05.
- Chaining: add 0x01+0x02 with wr_acc, then add `cmd_use_acc` b=0x04 with wr_acc → `acc`=0x03 then 0x07; `alu_a`=0x03 on the second op.
- Overflow: add 0xFF+0x01 → `res_y`=0x00, carry=1, zero=1.
- Backpressure: `res_ready` low for 10 cycles → `res_valid` and `res_y` stable, `cmd_ready`=0, `cmd_valid` ignored; release → single handshake, `op_count`+1.
- Reset mid-op: assert `rst_n` low in ISSUE → all outputs 0 immediately, `cmd_ready`=1, no result emitted after release. Also preload `op_count` to 0xFFFF via 65535 ops (or force), run one more op → `op_count` remains 0xFFFF.
